// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Shared encodings for the split shift accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam logic [2:0] OP_HOLD      = 3'b000;
    localparam logic [2:0] OP_LOAD_HIGH = 3'b001;
    localparam logic [2:0] OP_LOAD_LOW  = 3'b010;
    localparam logic [2:0] OP_SHR1      = 3'b011;
    localparam logic [2:0] OP_SHL1      = 3'b100;
    localparam logic [2:0] OP_SHRN      = 3'b101;
    localparam logic [2:0] OP_SHLN      = 3'b110;

    localparam logic [1:0] MODE_LOG   = 2'b00;
    localparam logic [1:0] MODE_FILL  = 2'b01;
    localparam logic [1:0] MODE_ARITH = 2'b10;
    localparam logic [1:0] MODE_ROT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/acc_half_reg.sv
`default_nettype none
// ============================================================================
// Module      : acc_half_reg
// Description : One accumulator half with a tri-state bus read port.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_half_reg #(
    parameter int HALF = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [HALF-1:0] i_d,
    input  logic            i_rd_en,
    output logic [HALF-1:0] o_q,
    output logic [HALF-1:0] o_bus
);

    logic [HALF-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q   = r_q;
    assign o_bus = i_rd_en ? r_q : {HALF{1'bz}};

endmodule
`default_nettype wire

// File: rtl/acc_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : acc_shift_seq
// Description : Split WIDTH-bit accumulator with mode-selectable single and
//               sequenced multi-bit shifts, busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_shift_seq
    import acc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int HALF  = WIDTH / 2,
    localparam int SHW   = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            acc_high_clear,
    input  logic [2:0]      op,
    input  logic [1:0]      shift_mode,
    input  logic [SHW-1:0]  shamt,
    input  logic            fill_value,
    input  logic            acc_in_select,
    input  logic [HALF-1:0] bus_data,
    input  logic [HALF-1:0] alu_data,
    input  logic            rd_en,
    output logic [HALF-1:0] high_data2bus,
    output logic [HALF-1:0] low_data2bus,
    output logic [HALF-1:0] acc_high_data,
    output logic [HALF-1:0] acc_low_data,
    output logic            shift_out,
    output logic            busy,
    output logic            done
);

    state_t         r_state, w_state_nxt;
    logic [SHW-1:0] r_cnt, w_cnt_nxt;
    logic           r_dir_left, w_dir_left_nxt;
    logic [1:0]     r_mode, w_mode_nxt;
    logic           r_fill, w_fill_nxt;
    logic           r_shift_out, w_so_nxt;

    logic [HALF-1:0]  w_high_q, w_low_q, w_high_nxt, w_low_nxt;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH:0]   w_step;
    logic             w_step_left, w_step_fill;
    logic [1:0]       w_step_mode;
    logic [SHW-1:0]   w_sat;

    // Returns {bit shifted out, shifted value}; halves are treated as one word.
    function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic left,
                                                  input logic [1:0] mode,
                                                  input logic fill);
        logic in_bit;
        if (left) begin
            case (mode)
                MODE_FILL:            in_bit = fill;
                MODE_ROT:             in_bit = v[WIDTH-1];
                MODE_LOG, MODE_ARITH: in_bit = 1'b0;
                default:              in_bit = 1'b0;
            endcase
            return {v[WIDTH-1], v[WIDTH-2:0], in_bit};
        end else begin
            case (mode)
                MODE_FILL:  in_bit = fill;
                MODE_ARITH: in_bit = v[WIDTH-1];
                MODE_ROT:   in_bit = v[0];
                MODE_LOG:   in_bit = 1'b0;
                default:    in_bit = 1'b0;
            endcase
            return {v[0], in_bit, v[WIDTH-1:1]};
        end
    endfunction

    assign w_acc = {w_high_q, w_low_q};

    // Single step engine shared by IDLE single shifts and the sequencer.
    assign w_step_left = (r_state == ST_SHIFT) ? r_dir_left : (op == OP_SHL1);
    assign w_step_mode = (r_state == ST_SHIFT) ? r_mode     : shift_mode;
    assign w_step_fill = (r_state == ST_SHIFT) ? r_fill     : fill_value;
    assign w_step      = shift_step(w_acc, w_step_left, w_step_mode, w_step_fill);
    assign w_sat       = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dir_left_nxt = r_dir_left;
        w_mode_nxt     = r_mode;
        w_fill_nxt     = r_fill;
        w_so_nxt       = r_shift_out;
        w_high_nxt     = w_high_q;
        w_low_nxt      = w_low_q;

        case (r_state)
            ST_IDLE: begin
                case (op)
                    OP_HOLD: ;
                    OP_LOAD_HIGH: w_high_nxt = acc_in_select ? bus_data : alu_data;
                    OP_LOAD_LOW:  w_low_nxt  = w_high_q;
                    OP_SHR1, OP_SHL1: {w_so_nxt, w_high_nxt, w_low_nxt} = w_step;
                    OP_SHRN, OP_SHLN: begin
                        w_dir_left_nxt = (op == OP_SHLN);
                        w_mode_nxt     = shift_mode;
                        w_fill_nxt     = fill_value;
                        w_cnt_nxt      = w_sat;
                        w_state_nxt    = (w_sat == '0) ? ST_FIN : ST_SHIFT;
                    end
                    default: ;
                endcase
                // Clear wins over load and overrides the high half of a shift result.
                if (acc_high_clear) begin
                    w_high_nxt = '0;
                end
            end
            ST_SHIFT: begin
                {w_so_nxt, w_high_nxt, w_low_nxt} = w_step;
                w_cnt_nxt = r_cnt - SHW'(1);
                if (r_cnt <= SHW'(1)) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dir_left  <= 1'b0;
            r_mode      <= MODE_LOG;
            r_fill      <= 1'b0;
            r_shift_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dir_left  <= w_dir_left_nxt;
            r_mode      <= w_mode_nxt;
            r_fill      <= w_fill_nxt;
            r_shift_out <= w_so_nxt;
        end
    end

    acc_half_reg #(.HALF(HALF)) u_high (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_d     (w_high_nxt),
        .i_rd_en (rd_en),
        .o_q     (w_high_q),
        .o_bus   (high_data2bus)
    );

    acc_half_reg #(.HALF(HALF)) u_low (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_d     (w_low_nxt),
        .i_rd_en (rd_en),
        .o_q     (w_low_q),
        .o_bus   (low_data2bus)
    );

    assign acc_high_data = w_high_q;
    assign acc_low_data  = w_low_q;
    assign shift_out     = r_shift_out;
    assign busy          = (r_state == ST_SHIFT);
    assign done          = (r_state == ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_acc_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_shift_seq
// Description : Scoreboard bench for acc_shift_seq with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_shift_seq;

    localparam logic [2:0] C_HOLD = 3'b000, C_LH = 3'b001, C_LL = 3'b010,
                           C_SHR1 = 3'b011, C_SHL1 = 3'b100,
                           C_SHRN = 3'b101, C_SHLN = 3'b110;
    localparam logic [1:0] C_LOG = 2'b00, C_FILL = 2'b01, C_ARITH = 2'b10, C_ROT = 2'b11;

    logic       clk;
    logic       reset_n;
    logic       acc_high_clear;
    logic [2:0] op;
    logic [1:0] shift_mode;
    logic [3:0] shamt;
    logic       fill_value;
    logic       acc_in_select;
    logic [3:0] bus_data;
    logic [3:0] alu_data;
    logic       rd_en;
    wire  [3:0] high_data2bus;
    wire  [3:0] low_data2bus;
    wire  [3:0] acc_high_data;
    wire  [3:0] acc_low_data;
    wire        shift_out;
    wire        busy;
    wire        done;

    acc_shift_seq #(.WIDTH(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .acc_high_clear (acc_high_clear),
        .op             (op),
        .shift_mode     (shift_mode),
        .shamt          (shamt),
        .fill_value     (fill_value),
        .acc_in_select  (acc_in_select),
        .bus_data       (bus_data),
        .alu_data       (alu_data),
        .rd_en          (rd_en),
        .high_data2bus  (high_data2bus),
        .low_data2bus   (low_data2bus),
        .acc_high_data  (acc_high_data),
        .acc_low_data   (acc_low_data),
        .shift_out      (shift_out),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        string      name;
        int         cyc;
        logic [7:0] acc;
        logic       so;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_item(input exp_t e);
        logic [10:0] act, req;
        act = {acc_high_data, acc_low_data, shift_out, busy, done};
        req = {e.acc, e.so, e.busy, e.done};
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: acc=%h so=%b busy=%b done=%b, required acc=%h so=%b busy=%b done=%b",
                      e.name, act[10:3], act[2], act[1], act[0], e.acc, e.so, e.busy, e.done);
        n_checks++;
        if (rd_en) begin
            if ({high_data2bus, low_data2bus} === e.acc) n_pass++;
            else $display("FAIL %s_bus: bus=%h, required %h", e.name,
                          {high_data2bus, low_data2bus}, e.acc);
        end else begin
            // A released port reads as Z in 4-state tools and as 0 in 2-state ones.
            if ((high_data2bus === 4'bzzzz || high_data2bus == 4'h0) &&
                (low_data2bus  === 4'bzzzz || low_data2bus  == 4'h0)) n_pass++;
            else $display("FAIL %s_busz: bus=%h, required high-Z", e.name,
                          {high_data2bus, low_data2bus});
        end
    endtask

    // Monitor: compares every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                check_item(q[i]);
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input string name, input int off, input logic [7:0] acc,
                             input logic so, input logic b, input logic d);
        exp_t e;
        e.name = name; e.cyc = cyc + off; e.acc = acc; e.so = so; e.busy = b; e.done = d;
        q.push_back(e);
    endtask

    task automatic cmd(input logic [2:0] o, input logic [1:0] m, input logic [3:0] n,
                       input logic f, input logic sel, input logic [3:0] d, input logic clr);
        @(posedge clk);
        #2;
        op             = o;
        shift_mode     = m;
        shamt          = n;
        fill_value     = f;
        acc_in_select  = sel;
        bus_data       = sel ? d : ~d;
        alu_data       = sel ? ~d : d;
        acc_high_clear = clr;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cmd(C_HOLD, C_LOG, 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic load8(input logic [7:0] v, input logic so, input string name);
        logic [7:0] t;
        t = v;
        cmd(C_LH, C_LOG, 4'd0, 1'b0, 1'b1, t[3:0], 1'b0);
        cmd(C_LL, C_LOG, 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        cmd(C_LH, C_LOG, 4'd0, 1'b0, 1'b1, t[7:4], 1'b0);
        expect_at(name, 1, v, so, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; rd_en = 1'b1; acc_high_clear = 1'b0; op = C_HOLD;
        shift_mode = C_LOG; shamt = 4'd0; fill_value = 1'b0; acc_in_select = 1'b0;
        bus_data = 4'h0; alu_data = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        expect_at("reset", 1, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        cmd(C_LH, C_LOG, 4'd0, 1'b0, 1'b1, 4'hA, 1'b0); expect_at("load_high_bus", 1, 8'hA0, 0, 0, 0);
        cmd(C_LL, C_LOG, 4'd0, 1'b0, 1'b0, 4'h0, 1'b0); expect_at("load_low", 1, 8'hAA, 0, 0, 0);
        cmd(C_LH, C_LOG, 4'd0, 1'b0, 1'b0, 4'h3, 1'b0); expect_at("load_high_alu", 1, 8'h3A, 0, 0, 0);
        rd_en = 1'b0;
        hold(1); expect_at("hold_rd0_a", 1, 8'h3A, 0, 0, 0);
        hold(1); expect_at("hold_rd0_b", 1, 8'h3A, 0, 0, 0);
        rd_en = 1'b1;

        load8(8'h96, 1'b0, "load_96");
        cmd(C_SHR1, C_ARITH, 4'd0, 1'b0, 1'b0, 4'h0, 1'b0); expect_at("shr1_arith", 1, 8'hCB, 0, 0, 0);
        cmd(C_SHL1, C_ROT,   4'd0, 1'b0, 1'b0, 4'h0, 1'b0); expect_at("shl1_rot",   1, 8'h97, 1, 0, 0);
        load8(8'h02, 1'b1, "load_02");
        cmd(C_SHR1, C_FILL,  4'd0, 1'b1, 1'b0, 4'h0, 1'b0); expect_at("shr1_fill",  1, 8'h81, 0, 0, 0);

        cmd(C_SHLN, C_LOG, 4'd3, 1'b0, 1'b0, 4'h0, 1'b0);
        expect_at("shln_start", 1, 8'h81, 0, 1, 0);
        expect_at("shln_s1",    2, 8'h02, 1, 1, 0);
        expect_at("shln_s2",    3, 8'h04, 0, 1, 0);
        expect_at("shln_done",  4, 8'h08, 0, 0, 1);
        expect_at("shln_idle",  5, 8'h08, 0, 0, 0);
        cmd(C_LH,   C_LOG, 4'd0, 1'b0, 1'b1, 4'hF, 1'b0);
        cmd(C_HOLD, C_LOG, 4'd0, 1'b0, 1'b0, 4'h0, 1'b1);
        hold(1);
        cmd(C_LH,   C_LOG, 4'd0, 1'b0, 1'b1, 4'hF, 1'b0);

        cmd(C_SHRN, C_LOG, 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        expect_at("shamt0_done", 1, 8'h08, 0, 0, 1);
        expect_at("shamt0_idle", 2, 8'h08, 0, 0, 0);
        hold(1);

        load8(8'h5C, 1'b0, "load_5c");
        cmd(C_SHRN, C_ROT, 4'd8, 1'b0, 1'b0, 4'h0, 1'b0);
        expect_at("rot8_busy", 1, 8'h5C, 0, 1, 0);
        expect_at("rot8_mid",  5, 8'hC5, 1, 1, 0);
        expect_at("rot8_done", 9, 8'h5C, 0, 0, 1);
        hold(9);

        load8(8'hA5, 1'b0, "load_a5");
        cmd(C_SHRN, C_LOG, 4'd12, 1'b0, 1'b0, 4'h0, 1'b0);
        expect_at("sat_step7", 8,  8'h01, 0, 1, 0);
        expect_at("sat_done",  9,  8'h00, 1, 0, 1);
        expect_at("sat_idle",  10, 8'h00, 1, 0, 0);
        hold(9);

        cmd(C_LH, C_LOG, 4'd0, 1'b0, 1'b1, 4'h7, 1'b0);
        cmd(C_LL, C_LOG, 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        cmd(C_LH, C_LOG, 4'd0, 1'b0, 1'b1, 4'hE, 1'b1); expect_at("clr_prio",  1, 8'h07, 1, 0, 0);
        cmd(C_LH, C_LOG, 4'd0, 1'b0, 1'b1, 4'h9, 1'b0); expect_at("load_97",   1, 8'h97, 1, 0, 0);
        cmd(C_SHL1, C_LOG, 4'd0, 1'b0, 1'b0, 4'h0, 1'b1); expect_at("clr_shift", 1, 8'h0E, 1, 0, 0);

        cmd(C_LH, C_LOG, 4'd0, 1'b0, 1'b1, 4'h3, 1'b0); expect_at("load_3e", 1, 8'h3E, 1, 0, 0);
        cmd(C_SHRN, C_LOG, 4'd5, 1'b0, 1'b0, 4'h0, 1'b0); expect_at("rst_busy", 1, 8'h3E, 1, 1, 0);
        hold(1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        expect_at("rst_abort", 0, 8'h00, 0, 0, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) expect_at("rst_no_done", k, 8'h00, 0, 0, 0);
        hold(4);
        cmd(C_LH,   C_LOG, 4'd0, 1'b0, 1'b1, 4'h6, 1'b0); expect_at("after_rst_load", 1, 8'h60, 0, 0, 0);
        cmd(C_SHR1, C_LOG, 4'd0, 1'b0, 1'b0, 4'h0, 1'b0); expect_at("after_rst_shr",  1, 8'h30, 0, 0, 0);
        hold(1);
        repeat (3) @(posedge clk);

        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d expectations never checked, required 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
